fetch_unit: RTL

Front-end fetch stage between the instruction cache and the decoder. It issues sequential instruction-fetch requests to the icache side of the ICache/Fetch interface and buffers returned instructions in a small in-order queue. It presents the queued instructions to decode through the Fetch/Decode interface, honouring `dec_stall` back-pressure. A one-cycle redirect input restarts fetch at a new PC, flushing the queue and discarding in-flight responses.

---
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit.sv | 106 ++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: icache response, fetch request, decode delivery and
// redirect. Every *_e_ enable is active-low: a transfer of the associated data
// happens in a cycle where the enable is 0. The icache accepts every request,
// so fetch_e_ needs no ready. Decode back-pressures the queue head with
// dec_stall: the head is consumed only in a cycle with inst_e_=0 and
// dec_stall=0, and it is held unchanged while stalled.
interface fetch_unit_if #(
    parameter int ADDR = 32,
    parameter int INST = 32
);
    logic            ic_e_;
    logic [ADDR-1:0] ic_pc;
    logic [INST-1:0] ic_inst;
    logic            fetch_e_;
    logic [ADDR-1:0] fetch_pc;
    logic            dec_stall;
    logic            inst_e_;
    logic [ADDR-1:0] inst_pc;
    logic [INST-1:0] inst;
    logic            redirect_e_;
    logic [ADDR-1:0] redirect_pc;

    // Fetch unit side.
    modport master (
        input  ic_e_, ic_pc, ic_inst, dec_stall, redirect_e_, redirect_pc,
        output fetch_e_, fetch_pc, inst_e_, inst_pc, inst
    );

    // Environment side (icache, decode, branch resolve).
    modport slave (
        output ic_e_, ic_pc, ic_inst, dec_stall, redirect_e_, redirect_pc,
        input  fetch_e_, fetch_pc, inst_e_, inst_pc, inst
    );
endinterface

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with an in-order return queue. Requests are
// issued only while queued + outstanding instructions fit in the queue, so a
// response can always be enqueued. A redirect flushes the queue and marks the
// responses still in flight for discard.
module fetch_unit #(
    parameter int              ADDR     = 32,
    parameter int              INST     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [ADDR-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    fetch_unit_if.master                 bus,
    output logic [$clog2(QDEPTH+1)-1:0]  o_dbg_count,
    output logic [$clog2(QDEPTH+1)-1:0]  o_dbg_outst,
    output logic [$clog2(QDEPTH+1)-1:0]  o_dbg_discard
);
    localparam int              PW    = $clog2(QDEPTH);
    localparam int              CW    = $clog2(QDEPTH + 1);
    localparam int              CW1   = CW + 1;
    localparam logic [ADDR-1:0] STEP  = ADDR'(INST / 8);
    localparam logic [CW:0]     LIMIT = CW1'(QDEPTH);

    logic [ADDR-1:0] r_pc;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outst;
    logic [CW-1:0]   r_discard;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [ADDR-1:0] r_mem_pc   [QDEPTH];
    logic [INST-1:0] r_mem_inst [QDEPTH];

    logic          w_resp;
    logic          w_redirect;
    logic [CW:0]   w_credit;
    logic          w_issue;
    logic          w_has_head;
    logic          w_pop;
    logic          w_drop;
    logic          w_push;
    logic [CW-1:0] w_outst_redirect;

    assign w_resp     = ~bus.ic_e_;
    assign w_redirect = ~bus.redirect_e_;
    // Registered count only: a pop in the same cycle does not free a slot yet.
    assign w_credit   = {1'b0, r_count} + {1'b0, r_outst};
    assign w_issue    = ~reset & ~w_redirect & (w_credit < LIMIT);
    assign w_has_head = (r_count != '0);
    assign w_pop      = w_has_head & ~bus.dec_stall & ~w_redirect;
    assign w_drop     = w_resp & (r_discard != '0);
    assign w_push     = w_resp & ~w_drop & ~w_redirect & ~reset;
    // A response landing in the redirect cycle retires one in-flight request.
    assign w_outst_redirect = r_outst - CW'(w_resp);

    assign bus.fetch_e_ = ~w_issue;
    assign bus.fetch_pc = r_pc;
    assign bus.inst_e_  = ~w_has_head;
    assign bus.inst_pc  = w_has_head ? r_mem_pc[r_head]   : '0;
    assign bus.inst     = w_has_head ? r_mem_inst[r_head] : '0;

    assign o_dbg_count   = r_count;
    assign o_dbg_outst   = r_outst;
    assign o_dbg_discard = r_discard;

    // Control state: PC, queue pointers/occupancy, in-flight and discard counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_count   <= '0;
            r_outst   <= '0;
            r_discard <= '0;
            r_head    <= '0;
            r_tail    <= '0;
        end else if (w_redirect) begin
            r_pc      <= bus.redirect_pc;
            r_count   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_outst   <= w_outst_redirect;
            r_discard <= w_outst_redirect;
        end else begin
            if (w_issue) begin
                r_pc <= r_pc + STEP;
            end
            r_outst <= r_outst + CW'(w_issue) - CW'(w_resp);
            if (w_drop) begin
                r_discard <= r_discard - 1'b1;
            end
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Queue storage: written at the tail on every accepted response.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_tail]   <= bus.ic_pc;
            r_mem_inst[r_tail] <= bus.ic_inst;
        end
    end
endmodule
